tow_cyber_player: RTL

- Computer opponent for the tug-of-war game. It generates key presses instead of receiving them.
- Output key_n is an active-low raw key level, shaped like a physical KEY. It feeds the same tow_input conditioner a human key uses, so the player slot needs no other change.
- Press rate is pseudo-random and set by a 3-bit speed input driven from SW. The block stops when the game ends.

---
 rtl/tow_pkg.sv | 26 ++
 rtl/tow_lfsr.sv | 43 ++++
 rtl/tow_cyber_player.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/tow_pkg.sv
// rtl/tow_pkg.sv - shared types, constants and helpers for the computer tug-of-war player
//
// Contents:
//   cyber_state_t           FSM states of the computer player
//   LFSR_W, LFSR_TAP_A/B    width and feedback taps of the press-decision LFSR
//   tow_threshold(speed)    LFSR compare threshold for a 3-bit speed setting

package tow_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        PRESS = 2'd2,
        GAP   = 2'd3
    } cyber_state_t;

    localparam int LFSR_W     = 10;
    localparam int LFSR_TAP_A = 9;
    localparam int LFSR_TAP_B = 6;

    // Each speed step adds 128/1023 to the press probability per tick.
    function automatic logic [LFSR_W-1:0] tow_threshold(input logic [2:0] speed);
        return {speed, 7'b0};
    endfunction

endpackage

// File: rtl/tow_lfsr.sv
// rtl/tow_lfsr.sv - 10-bit Fibonacci LFSR (x^10+x^7+1) stepping on demand
//
// Ports:
//   clk      in   system clock
//   reset    in   synchronous active-low reset, loads SEED (0 is forced to 1)
//   advance  in   shift one step this cycle
//   q        out  current LFSR value, never zero

module tow_lfsr
    import tow_pkg::*;
#(
    parameter logic [LFSR_W-1:0] SEED = 10'h001
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              advance,
    output logic [LFSR_W-1:0] q
);

    // The all-zero state is a lock-up point, so a zero seed starts from 1.
    localparam logic [LFSR_W-1:0] SEED_FIX = (SEED == '0) ? LFSR_W'(1) : SEED;

    logic [LFSR_W-1:0] q_q;
    logic [LFSR_W-1:0] q_d;

    always_comb begin
        q_d = q_q;
        if (advance) begin
            q_d = {q_q[LFSR_W-2:0], q_q[LFSR_TAP_A] ^ q_q[LFSR_TAP_B]};
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            q_q <= SEED_FIX;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/tow_cyber_player.sv
// rtl/tow_cyber_player.sv - computer opponent emitting pseudo-random raw key presses
//
// Ports:
//   clk        in   system clock
//   reset      in   synchronous active-low reset
//   enable     in   computer player active
//   game_over  in   a victor exists; halts pressing
//   speed      in   3-bit press probability, 0 = never press
//   key_n      out  emulated raw key level, 0 = pressed
//   press      out  one-cycle pulse on the first low cycle of key_n
//   presses    out  saturating count of presses since reset

module tow_cyber_player
    import tow_pkg::*;
#(
    parameter int                TICK_DIV       = 16,
    parameter int                HOLD_CYCLES    = 4,
    parameter int                RELEASE_CYCLES = 4,
    parameter logic [LFSR_W-1:0] SEED           = 10'h001
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       game_over,
    input  logic [2:0] speed,
    output logic       key_n,
    output logic       press,
    output logic [7:0] presses
);

    localparam int TICK_W = $clog2(TICK_DIV);
    localparam int HG_MAX = (HOLD_CYCLES > RELEASE_CYCLES) ? HOLD_CYCLES : RELEASE_CYCLES;
    localparam int HG_W   = (HG_MAX > 1) ? $clog2(HG_MAX) : 1;

    logic [TICK_W-1:0] tick_cnt_q;
    logic [TICK_W-1:0] tick_cnt_d;
    logic              tick;

    cyber_state_t      state_q;
    cyber_state_t      state_d;
    logic [HG_W-1:0]   hg_cnt_q;
    logic [HG_W-1:0]   hg_cnt_d;
    logic              key_n_q;
    logic              key_n_d;
    logic              press_q;
    logic              press_d;
    logic [7:0]        presses_q;
    logic [7:0]        presses_d;

    logic [LFSR_W-1:0] lfsr_q;
    logic              hit;
    logic              go;

    // Free-running decision tick, independent of FSM state.
    assign tick = (tick_cnt_q == TICK_W'(TICK_DIV - 1));

    always_comb begin
        tick_cnt_d = tick ? '0 : tick_cnt_q + TICK_W'(1);
    end

    tow_lfsr #(
        .SEED (SEED)
    ) u_lfsr (
        .clk     (clk),
        .reset   (reset),
        .advance (tick),
        .q       (lfsr_q)
    );

    // Decision uses the LFSR value present in the tick cycle, before it steps.
    assign hit = (speed != 3'd0) && (lfsr_q < tow_threshold(speed));
    assign go  = enable && !game_over;

    always_comb begin
        state_d   = state_q;
        hg_cnt_d  = hg_cnt_q;
        press_d   = 1'b0;
        presses_d = presses_q;

        case (state_q)
            IDLE: begin
                if (go) state_d = WAIT;
            end
            WAIT: begin
                if (!go)             state_d = IDLE;
                else if (tick && hit) state_d = PRESS;
            end
            PRESS: begin
                if (!go)                 state_d = IDLE;
                else if (hg_cnt_q == '0) state_d = GAP;
                else                     hg_cnt_d = hg_cnt_q - HG_W'(1);
            end
            GAP: begin
                if (!go)                 state_d = IDLE;
                else if (hg_cnt_q == '0) state_d = WAIT;
                else                     hg_cnt_d = hg_cnt_q - HG_W'(1);
            end
            default: state_d = IDLE;
        endcase

        // Counter holds "remaining cycles after this one", reloaded on entry.
        if (state_d != state_q) begin
            case (state_d)
                PRESS:   hg_cnt_d = HG_W'(HOLD_CYCLES - 1);
                GAP:     hg_cnt_d = HG_W'(RELEASE_CYCLES - 1);
                default: hg_cnt_d = '0;
            endcase
        end

        if ((state_q == WAIT) && (state_d == PRESS)) begin
            press_d = 1'b1;
            if (presses_q != 8'hFF) presses_d = presses_q + 8'd1;
        end

        key_n_d = (state_d != PRESS);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            tick_cnt_q <= '0;
            state_q    <= IDLE;
            hg_cnt_q   <= '0;
            key_n_q    <= 1'b1;
            press_q    <= 1'b0;
            presses_q  <= 8'd0;
        end else begin
            tick_cnt_q <= tick_cnt_d;
            state_q    <= state_d;
            hg_cnt_q   <= hg_cnt_d;
            key_n_q    <= key_n_d;
            press_q    <= press_d;
            presses_q  <= presses_d;
        end
    end

    assign key_n   = key_n_q;
    assign press   = press_q;
    assign presses = presses_q;

endmodule
